// File: rtl/mp_add_seq.sv
// Multi-precision add sequencer: walks WORDS 16-bit slices through an external
// 16-bit adder LSB-first, chaining carry, and presents the full sum downstream.
module mp_add_seq #(
  parameter int WORDS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [16*WORDS-1:0]   in_a,
  input  logic [16*WORDS-1:0]   in_b,
  input  logic                  in_cin,
  output logic [15:0]           add_a,
  output logic [15:0]           add_b,
  output logic                  add_cin,
  input  logic [15:0]           add_s,
  input  logic                  add_cout,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [16*WORDS-1:0]   out_sum,
  output logic                  out_cout,
  output logic                  out_ovf,
  output logic [1:0]            dbg_state
);

  localparam int W  = 16 * WORDS;
  localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [IW-1:0] LAST = IW'(WORDS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [W-1:0]    a_q, a_d;
  logic [W-1:0]    b_q, b_d;
  logic [W-1:0]    sum_q, sum_d;
  logic            carry_q, carry_d;
  logic            in_ready_q, in_ready_d;
  logic            out_valid_q, out_valid_d;

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high; ready/valid outputs are registered state decodes only.

  // Slice mux toward the external adder; zero whenever not in RUN.
  always_comb begin
    add_a   = '0;
    add_b   = '0;
    add_cin = 1'b0;
    if (state_q == RUN) begin
      add_cin = carry_q;
      for (int i = 0; i < WORDS; i++) begin
        if (idx_q == IW'(i)) begin
          add_a = a_q[16*i +: 16];
          add_b = b_q[16*i +: 16];
        end
      end
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = in_a;
          b_d     = in_b;
          carry_d = in_cin;
          idx_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        for (int i = 0; i < WORDS; i++) begin
          if (idx_q == IW'(i)) sum_d[16*i +: 16] = add_s;
        end
        carry_d = add_cout;
        if (idx_q == LAST) begin
          idx_d   = '0;
          state_d = DONE;
        end else begin
          idx_d = idx_q + IW'(1);
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      sum_q       <= '0;
      carry_q     <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      a_q         <= a_d;
      b_q         <= b_d;
      sum_q       <= sum_d;
      carry_q     <= carry_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_sum   = sum_q;
  assign out_cout  = carry_q;
  assign out_ovf   = (a_q[W-1] == b_q[W-1]) && (sum_q[W-1] != a_q[W-1]);
  assign dbg_state = state_q;

endmodule
